dac_cmd_serializer: RTL
=======================

Name: dac_cmd_serializer

Overview:
Parametrised DAC command builder and serial loader for the front-end card's multi-channel DAC.
- Maps a channel index to a DAC address code using a programmable offset, so ch0→0010 … ch7→1001 by default.
- Concatenates the code with the DAC data value and shifts the frame out on a 3-wire SYNC/SCLK/DIN interface.
- Supports single-channel writes and a broadcast mode that loads the same value into every channel back-to-back.
- Sits between the slow-control register file and the DAC pins.

Parameters:
N_CH, 8, number of DAC channels addressable.
ADDR_W, 3, width of channel index input.
CODE_W, 4, width of DAC address code field.
CODE_OFFSET, 2, code = (ch + CODE_OFFSET) mod 2^CODE_W.
DATA_W, 10, DAC data field width.
PAD_W, 2, trailing zero bits after data. Frame width FW = CODE_W+DATA_W+PAD_W (16).
CLK_DIV, 4, clk cycles per SCLK half-period (≥1).
GAP_CYC, 4, clk cycles SYNC held high between frames (≥1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-channel write request, sampled in IDLE only
start_all  in  1  broadcast write request, sampled in IDLE only
ch  in  ADDR_W  target channel for start
data  in  DATA_W  DAC value, latched with the request
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of request
err  out  1  one-cycle pulse when a request is rejected
code_out  out  CODE_W  address code of current or last frame
dac_sync_n  out  1  frame select, active low
dac_sclk  out  1  serial clock, idle high
dac_din  out  1  serial data, MSB first

Behaviour:
- Reset (asynchronous, any time, including mid-frame) forces the following, and the FSM goes to IDLE:
  - dac_sync_n=1, dac_sclk=1, dac_din=0.
  - busy=0, done=0, err=0, code_out=0.
- FSM states: IDLE, SHIFT, GAP, FIN.
- IDLE, request sampled at edge k:
  - start and start_all both high: start_all wins.
  - start with ch ≥ N_CH: err=1 for one cycle at edge k+1; stays in IDLE; no pin activity.
  - Accepted request:
    - Latch data and the channel (ch for start, 0 for start_all).
    - Frame = {code, data, PAD_W zeros}.
    - At edge k+1: busy=1, dac_sync_n=0, dac_din=frame MSB, dac_sclk=1, code_out=code; enter SHIFT.
- SHIFT, per bit, 2×CLK_DIV cycles:
  - First CLK_DIV cycles: sclk high with din stable.
  - Next CLK_DIV cycles: sclk low. The DAC samples on the falling edge.
  - On the rising transition, din advances to the next bit.
  - After the low phase of bit 0 (LSB): sclk=1, sync_n=1, din=0; enter GAP.
  - sync_n is low for exactly FW×2×CLK_DIV cycles (128 with defaults).
- GAP: hold for GAP_CYC cycles.
  - Broadcast with more channels left: increment channel, rebuild frame, assert sync_n=0, return to SHIFT.
  - Otherwise enter FIN.
- FIN: one cycle with done=1, then busy=0 and return to IDLE. Next request can be sampled the cycle after done.
- Latency, single write with defaults: done high at edge k+1+128+4 = k+133.
- Broadcast:
  - N_CH frames for channels 0..N_CH-1, each separated by GAP_CYC cycles of sync high.
  - Only one done, after the last frame's GAP.
  - code_out tracks each frame.
- start/start_all while busy: ignored, with no err.
- ch and data changing during busy: no effect, because both are latched.
- Code arithmetic:
  - Modulo 2^CODE_W, so wrap-around is allowed.
  - Code width truncation is silent.

Test Plan:
- Reset then start, ch=5, data=10'h2A5, defaults:
  - code_out=4'b0111.
  - 16 falling SCLK edges while sync_n low, sampling 16'h7A94 MSB first.
  - sync_n low for 128 cycles.
  - done at k+133.
- Sweep ch 0..7 with single writes: codes 0010,0011,…,1001 observed on the first 4 serial bits and code_out.
- start_all, data=10'h3FF:
  - 8 frames with codes 0010..1001, each with data bits all 1.
  - 4-cycle sync-high gaps.
  - Exactly one done pulse.
  - busy continuous.
- Invalid channel and simultaneous requests:
  - With N_CH=6, start with ch=6: err pulse at k+1, no sync_n activity, busy stays 0.
  - start and start_all in the same cycle: broadcast executes.
- Assert reset during bit 9 of a frame:
  - sync_n=1, sclk=1, din=0, busy=0 immediately, without waiting for a clock edge.
  - After release, a new start completes normally.
- Parameter variants:
  - CLK_DIV=1, CODE_OFFSET=14, ch=3: code 0001 (wrap), SCLK period 2 cycles.
  - start pulsed while busy: ignored.

Source files
------------

// File: rtl/dac_cmd_serializer.sv
// Builds {code, data, pad} DAC frames from a channel/value request and shifts them
// out MSB first on a SYNC_N/SCLK/DIN interface. Supports single writes and all-channel broadcast.
module dac_cmd_serializer #(
   parameter int N_CH        = 8,
   parameter int ADDR_W      = 3,
   parameter int CODE_W      = 4,
   parameter int CODE_OFFSET = 2,
   parameter int DATA_W      = 10,
   parameter int PAD_W       = 2,
   parameter int CLK_DIV     = 4,
   parameter int GAP_CYC     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              start_all,
   input  logic [ADDR_W-1:0] ch,
   input  logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [CODE_W-1:0] code_out,
   output logic              dac_sync_n,
   output logic              dac_sclk,
   output logic              dac_din
);

   localparam int FW    = CODE_W + DATA_W + PAD_W;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int BIT_W = $clog2(FW);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
   localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(FW - 1);
   localparam logic [ADDR_W-1:0] CH_LAST  = ADDR_W'(N_CH - 1);

   if (CLK_DIV < 1) begin : g_bad_div
      $error("CLK_DIV must be at least 1");
   end
   if (GAP_CYC < 1) begin : g_bad_gap
      $error("GAP_CYC must be at least 1");
   end
   if (FW < 2) begin : g_bad_fw
      $error("frame must be at least 2 bits wide");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, GAP, FIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ch_q;
   logic [DATA_W-1:0] data_q;
   logic              bcast;
   logic              pend;
   logic              err_pend;
   logic [FW-1:0]     sh;
   logic [DIV_W-1:0]  div_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [BIT_W-1:0]  bit_cnt;

   // Code arithmetic is modulo 2^CODE_W; the upper sum bits are dropped on purpose.
   function automatic logic [CODE_W-1:0] make_code(input logic [ADDR_W-1:0] c);
      logic [31:0] s;
      s = 32'(c) + 32'(CODE_OFFSET);
      return s[CODE_W-1:0];
   endfunction

   function automatic logic [FW-1:0] make_frame(input logic [ADDR_W-1:0] c,
                                                input logic [DATA_W-1:0] d);
      return FW'({make_code(c), d}) << PAD_W;
   endfunction

   logic              ch_bad;
   logic [ADDR_W-1:0] ld_ch;
   logic [FW-1:0]     ld_frame;
   logic [CODE_W-1:0] ld_code;

   assign ch_bad = 32'(ch) >= 32'(N_CH);

   // Frame to launch: the latched channel from IDLE, the next channel from a broadcast GAP.
   always_comb begin
      ld_ch    = (state == GAP) ? ch_q + ADDR_W'(1) : ch_q;
      ld_frame = make_frame(ld_ch, data_q);
      ld_code  = make_code(ld_ch);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         code_out   <= '0;
         dac_sync_n <= 1'b1;
         dac_sclk   <= 1'b1;
         dac_din    <= 1'b0;
         ch_q       <= '0;
         data_q     <= '0;
         bcast      <= 1'b0;
         pend       <= 1'b0;
         err_pend   <= 1'b0;
         sh         <= '0;
         div_cnt    <= '0;
         gap_cnt    <= '0;
         bit_cnt    <= '0;
      end else begin
         done     <= 1'b0;
         err      <= err_pend;
         err_pend <= 1'b0;
         case (state)
            IDLE: begin
               // Requests are taken one edge early so pins and err move one edge after sampling.
               if (pend) begin
                  pend       <= 1'b0;
                  busy       <= 1'b1;
                  dac_sync_n <= 1'b0;
                  dac_sclk   <= 1'b1;
                  dac_din    <= ld_frame[FW-1];
                  sh         <= ld_frame;
                  code_out   <= ld_code;
                  div_cnt    <= '0;
                  bit_cnt    <= BIT_MSB;
                  state      <= SHIFT;
               end else if (!err_pend) begin
                  if (start_all) begin
                     bcast  <= 1'b1;
                     ch_q   <= '0;
                     data_q <= data;
                     pend   <= 1'b1;
                  end else if (start) begin
                     if (ch_bad) begin
                        err_pend <= 1'b1;
                     end else begin
                        bcast  <= 1'b0;
                        ch_q   <= ch;
                        data_q <= data;
                        pend   <= 1'b1;
                     end
                  end
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (dac_sclk) begin
                     dac_sclk <= 1'b0;
                  end else if (bit_cnt == '0) begin
                     dac_sclk   <= 1'b1;
                     dac_sync_n <= 1'b1;
                     dac_din    <= 1'b0;
                     gap_cnt    <= '0;
                     state      <= GAP;
                  end else begin
                     dac_sclk <= 1'b1;
                     bit_cnt  <= bit_cnt - 1'b1;
                     sh       <= {sh[FW-2:0], 1'b0};
                     dac_din  <= sh[FW-2];
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (bcast && ch_q != CH_LAST) begin
                     ch_q       <= ld_ch;
                     dac_sync_n <= 1'b0;
                     dac_sclk   <= 1'b1;
                     dac_din    <= ld_frame[FW-1];
                     sh         <= ld_frame;
                     code_out   <= ld_code;
                     div_cnt    <= '0;
                     bit_cnt    <= BIT_MSB;
                     state      <= SHIFT;
                  end else begin
                     done  <= 1'b1;
                     state <= FIN;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
